// File: rtl/spi_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl_if
//
// Purpose: groups the request/response and serial-line signals of the
// spi_xfer_ctrl transfer controller into one bundle.
//
// Signals:
//   start      host -> ctrl   transfer request (taken only while busy = 0)
//   slave_sel  host -> ctrl   index of the chip select to assert
//   tx_data    host -> ctrl   word to send
//   miso       chain -> ctrl  serial data returned from the SPI chain
//   s_clk      ctrl -> chain  SPI serial clock, idles low
//   spi_cs     ctrl -> chain  one-hot active-high chip selects
//   mosi       ctrl -> chain  serial data out
//   rx_data    ctrl -> host   last received word
//   busy       ctrl -> host   transfer in progress
//   done       ctrl -> host   one-cycle pulse when rx_data is updated
//
// Modports:
//   master  the host/bench side that drives requests and miso
//   slave   the controller side
// ---------------------------------------------------------------------------
interface spi_xfer_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [SEL_W-1:0]  slave_sel;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              s_clk;
    logic [NUM_CS-1:0] spi_cs;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output slave_sel,
        output tx_data,
        output miso,
        input  s_clk,
        input  spi_cs,
        input  mosi,
        input  rx_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  slave_sel,
        input  tx_data,
        input  miso,
        output s_clk,
        output spi_cs,
        output mosi,
        output rx_data,
        output busy,
        output done
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Purpose: host-side SPI mode-0 transfer controller. A parallel request is
// turned into chip-select, serial clock and serial data; the returned
// serial stream is assembled into rx_data.
//
// Ports:
//   clk    system clock, every register on its rising edge
//   reset  synchronous active-high reset
//   bus    spi_xfer_ctrl_if.slave (start, slave_sel, tx_data, miso in;
//          s_clk, spi_cs, mosi, rx_data, busy, done out)
//
// Parameters:
//   DATA_W   bits per transfer (>= 2)
//   CLK_DIV  clk cycles per s_clk half-period (>= 1)
//   CS_GAP   clk cycles of chip-select setup and hold (>= 1)
//   NUM_CS   number of one-hot chip-select outputs
//
// Build option:
//   SPI_XFER_CTRL_LSB_FIRST_EN  when defined, data goes LSB first in both
//                               directions; otherwise MSB first.
//
// Sequence: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
// s_clk, spi_cs and mosi come straight from registers so they cannot glitch.
// ---------------------------------------------------------------------------
module spi_xfer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 1,
    parameter int NUM_CS  = 4
) (
    input  logic           clk,
    input  logic           reset,
    spi_xfer_ctrl_if.slave bus
);

    localparam int SEL_W = (NUM_CS > 1)  ? $clog2(NUM_CS)  : 1;
    localparam int GAP_W = (CS_GAP > 1)  ? $clog2(CS_GAP)  : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [GAP_W-1:0]  gap_q,     gap_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [DATA_W-1:0] tx_sh_q,   tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q,   rx_sh_d;
    logic              s_clk_q,   s_clk_d;
    logic [NUM_CS-1:0] cs_q,      cs_d;
    logic              mosi_q,    mosi_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    // One-hot decode of the requested select. An index at or above NUM_CS
    // matches no output, so such a transfer runs with every select low.
    logic [NUM_CS-1:0] cs_dec;

    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
        assign cs_dec[gi] = (bus.slave_sel == SEL_W'(gi));
    end

    // Bit-order dependent datapath. The transmit register rotates rather
    // than shifts: the bit leaving one end is never looked at again, and
    // rotating keeps every register bit in use.
    logic              first_bit;
    logic [DATA_W-1:0] tx_rot;
    logic              next_bit;
    logic [DATA_W-1:0] rx_shifted;

`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    assign first_bit  = bus.tx_data[0];
    assign tx_rot     = {tx_sh_q[0], tx_sh_q[DATA_W-1:1]};
    assign next_bit   = tx_rot[0];
    assign rx_shifted = {bus.miso, rx_sh_q[DATA_W-1:1]};
`else
    assign first_bit  = bus.tx_data[DATA_W-1];
    assign tx_rot     = {tx_sh_q[DATA_W-2:0], tx_sh_q[DATA_W-1]};
    assign next_bit   = tx_rot[DATA_W-1];
    assign rx_shifted = {rx_sh_q[DATA_W-2:0], bus.miso};
`endif

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        s_clk_d   = s_clk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                    tx_sh_d = bus.tx_data;
                    rx_sh_d = '0;
                    cs_d    = cs_dec;
                    mosi_d  = first_bit;
                    busy_d  = 1'b1;
                    gap_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end

            ST_SETUP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    s_clk_d = ~s_clk_q;
                    if (!s_clk_q) begin
                        // Rising edge: sample the returned bit.
                        rx_sh_d = rx_shifted;
                    end else if (bit_q == BIT_LAST) begin
                        // Falling edge after the final bit: mosi keeps the
                        // last bit through the hold window.
                        state_d = ST_HOLD;
                        gap_d   = '0;
                    end else begin
                        // Falling edge: present the next bit.
                        tx_sh_d = tx_rot;
                        mosi_d  = next_bit;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_DONE;
                    cs_d    = '0;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_DONE: begin
                // start is not looked at here; a new request is taken in
                // the IDLE cycle that follows.
                rx_data_d = rx_sh_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                s_clk_d = 1'b0;
                cs_d    = '0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            s_clk_q   <= 1'b0;
            cs_q      <= '0;
            mosi_q    <= 1'b0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            s_clk_q   <= s_clk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.s_clk   = s_clk_q;
    assign bus.spi_cs  = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_ctrl
//
// Two controllers share one clock:
//   dut0  defaults (DATA_W 8, CLK_DIV 2, CS_GAP 1, NUM_CS 4), miso either
//         looped from mosi or tied to a constant
//   dut1  CLK_DIV 1, CS_GAP 2, NUM_CS 3, miso looped from mosi
// Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0;
    logic reset1;
    logic loop0;
    logic miso_val0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    spi_xfer_ctrl_if #(.DATA_W(8), .NUM_CS(4)) bus0 ();
    spi_xfer_ctrl_if #(.DATA_W(8), .NUM_CS(3)) bus1 ();

    assign bus0.miso = loop0 ? bus0.mosi : miso_val0;
    assign bus1.miso = bus1.mosi;

    spi_xfer_ctrl #(.DATA_W(8), .CLK_DIV(2), .CS_GAP(1), .NUM_CS(4)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.slave)
    );

    spi_xfer_ctrl #(.DATA_W(8), .CLK_DIV(1), .CS_GAP(2), .NUM_CS(3)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    // Runs one dut0 transfer and gathers observations; n counts falling
    // edges after the accept edge (n = 0 is half a cycle after accept).
    task automatic xfer0(input logic [7:0] tx, input logic [1:0] sel,
                         input int restart_at, input int post_cycles,
                         output int lat, output int rises,
                         output logic [7:0] mosi_word, output int dones,
                         output int busy_cycles, output bit cs_bad,
                         output bit mosi_high, output bit rx_moved);
        logic       prev_sclk;
        logic [7:0] rx_init;
        logic [3:0] exp_cs;
        bit         fin;
        exp_cs      = 4'b0001 << sel;
        lat         = -1;
        rises       = 0;
        mosi_word   = 8'h00;
        dones       = 0;
        busy_cycles = 0;
        cs_bad      = 1'b0;
        mosi_high   = 1'b0;
        rx_moved    = 1'b0;
        prev_sclk   = 1'b0;
        fin         = 1'b0;
        rx_init     = bus0.rx_data;
        @(negedge clk);
        bus0.start     = 1'b1;
        bus0.tx_data   = tx;
        bus0.slave_sel = sel;
        @(negedge clk);
        bus0.start   = 1'b0;
        bus0.tx_data = 8'hFF;
        for (int n = 0; n < 200 && !fin; n++) begin
            if (n == restart_at) begin
                bus0.start   = 1'b1;
                bus0.tx_data = 8'h3C;
            end else begin
                bus0.start = 1'b0;
            end
            if (bus0.busy) begin
                busy_cycles++;
                if (bus0.spi_cs !== exp_cs) cs_bad = 1'b1;
            end
            if (bus0.mosi) mosi_high = 1'b1;
            if (bus0.s_clk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[6:0], bus0.mosi};
            end
            prev_sclk = bus0.s_clk;
            if (bus0.done) begin
                dones++;
                if (lat < 0) lat = n;
            end else if (lat < 0 && bus0.rx_data !== rx_init) begin
                rx_moved = 1'b1;
            end
            if (lat >= 0 && n >= lat + post_cycles) fin = 1'b1;
            else @(negedge clk);
        end
        bus0.start = 1'b0;
        $display("xfer dut0 tx=%02h sel=%0d rx=%02h lat=%0d rises=%0d mosi=%02h dones=%0d",
                 tx, sel, bus0.rx_data, lat, rises, mosi_word, dones);
    endtask

    task automatic test_reset();
        reset0 = 1'b1;
        reset1 = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus0.s_clk, bus0.spi_cs, bus0.mosi, bus0.busy, bus0.done} !== 8'h00) begin
            $display("FAIL reset_ctrl0: got %b expected 00000000",
                     {bus0.s_clk, bus0.spi_cs, bus0.mosi, bus0.busy, bus0.done});
        end else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'h00) $display("FAIL reset_rx0: got %02h expected 00", bus0.rx_data);
        else pass_cnt++;
        total_cnt++;
        if ({bus1.s_clk, bus1.spi_cs, bus1.mosi, bus1.busy, bus1.done, bus1.rx_data} !== 15'h0) begin
            $display("FAIL reset_dut1: got %h expected 0",
                     {bus1.s_clk, bus1.spi_cs, bus1.mosi, bus1.busy, bus1.done, bus1.rx_data});
        end else pass_cnt++;
        reset0 = 1'b0;
        reset1 = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus0.busy, bus0.done, bus0.s_clk} !== 3'b000)
            $display("FAIL idle_after_reset: got %b expected 000", {bus0.busy, bus0.done, bus0.s_clk});
        else pass_cnt++;
        $display("xfer reset released");
    endtask

    task automatic test_loopback();
        int lat, rises, dones, busy_cycles;
        logic [7:0] mw;
        bit cs_bad, mosi_high, rx_moved;
        loop0 = 1'b1;
        xfer0(8'hA5, 2'd2, -1, 5, lat, rises, mw, dones, busy_cycles, cs_bad, mosi_high, rx_moved);
        total_cnt++;
        if (lat !== 35) $display("FAIL loop_latency: got %0d expected 35", lat); else pass_cnt++;
        total_cnt++;
        if (rises !== 8) $display("FAIL loop_rises: got %0d expected 8", rises); else pass_cnt++;
        total_cnt++;
        if (mw !== 8'hA5) $display("FAIL loop_mosi: got %02h expected a5", mw); else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'hA5) $display("FAIL loop_rx: got %02h expected a5", bus0.rx_data); else pass_cnt++;
        total_cnt++;
        if (cs_bad !== 1'b0) $display("FAIL loop_cs: got bad=%0d expected 0 (cs 0100)", cs_bad); else pass_cnt++;
        total_cnt++;
        if (busy_cycles !== 34) $display("FAIL loop_busy: got %0d expected 34", busy_cycles); else pass_cnt++;
        total_cnt++;
        if (dones !== 1) $display("FAIL loop_dones: got %0d expected 1", dones); else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        int lat, rises, dones, busy_cycles;
        logic [7:0] mw;
        bit cs_bad, mosi_high, rx_moved;
        loop0 = 1'b1;
        xfer0(8'hA5, 2'd1, 10, 40, lat, rises, mw, dones, busy_cycles, cs_bad, mosi_high, rx_moved);
        total_cnt++;
        if (dones !== 1) $display("FAIL restart_dones: got %0d expected 1", dones); else pass_cnt++;
        total_cnt++;
        if (mw !== 8'hA5) $display("FAIL restart_mosi: got %02h expected a5", mw); else pass_cnt++;
        total_cnt++;
        if (busy_cycles !== 34) $display("FAIL restart_busy: got %0d expected 34", busy_cycles); else pass_cnt++;
        total_cnt++;
        if (lat !== 35) $display("FAIL restart_latency: got %0d expected 35", lat); else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'hA5) $display("FAIL restart_rx: got %02h expected a5", bus0.rx_data); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int lat, rises, dones, busy_cycles, early_done;
        logic [7:0] mw;
        bit cs_bad, mosi_high, rx_moved;
        loop0      = 1'b1;
        early_done = 0;
        @(negedge clk);
        bus0.start     = 1'b1;
        bus0.tx_data   = 8'h5A;
        bus0.slave_sel = 2'd3;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus0.done) early_done++;
            @(negedge clk);
        end
        reset0 = 1'b1;
        @(negedge clk);
        reset0 = 1'b0;
        total_cnt++;
        if ({bus0.s_clk, bus0.spi_cs, bus0.busy, bus0.done} !== 7'b0)
            $display("FAIL midreset_ctrl: got %b expected 0000000",
                     {bus0.s_clk, bus0.spi_cs, bus0.busy, bus0.done});
        else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'h00) $display("FAIL midreset_rx: got %02h expected 00", bus0.rx_data); else pass_cnt++;
        for (int n = 0; n < 40; n++) begin
            if (bus0.done) early_done++;
            @(negedge clk);
        end
        total_cnt++;
        if (early_done !== 0) $display("FAIL midreset_nodone: got %0d expected 0", early_done); else pass_cnt++;
        $display("xfer dut0 aborted by reset");
        xfer0(8'h96, 2'd0, -1, 2, lat, rises, mw, dones, busy_cycles, cs_bad, mosi_high, rx_moved);
        total_cnt++;
        if (bus0.rx_data !== 8'h96) $display("FAIL postreset_rx: got %02h expected 96", bus0.rx_data); else pass_cnt++;
        total_cnt++;
        if (lat !== 35) $display("FAIL postreset_latency: got %0d expected 35", lat); else pass_cnt++;
    endtask

    task automatic test_miso_fixed();
        int lat, rises, dones, busy_cycles;
        logic [7:0] mw;
        bit cs_bad, mosi_high, rx_moved;
        loop0     = 1'b0;
        miso_val0 = 1'b1;
        xfer0(8'h00, 2'd0, -1, 2, lat, rises, mw, dones, busy_cycles, cs_bad, mosi_high, rx_moved);
        total_cnt++;
        if (mosi_high !== 1'b0) $display("FAIL miso1_mosi_low: got high=%0d expected 0", mosi_high); else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'hFF) $display("FAIL miso1_rx: got %02h expected ff", bus0.rx_data); else pass_cnt++;
        miso_val0 = 1'b0;
        xfer0(8'h81, 2'd3, -1, 2, lat, rises, mw, dones, busy_cycles, cs_bad, mosi_high, rx_moved);
        total_cnt++;
        if (rx_moved !== 1'b0) $display("FAIL miso0_hold: got moved=%0d expected 0", rx_moved); else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'h00) $display("FAIL miso0_rx: got %02h expected 00", bus0.rx_data); else pass_cnt++;
        total_cnt++;
        if (mw !== 8'h81) $display("FAIL miso0_mosi: got %02h expected 81", mw); else pass_cnt++;
        total_cnt++;
        if (cs_bad !== 1'b0) $display("FAIL miso0_cs: got bad=%0d expected 0 (cs 1000)", cs_bad); else pass_cnt++;
        loop0 = 1'b1;
    endtask

    task automatic test_back_to_back();
        int busy_rise[$];
        int done_t[$];
        int rise_t[$];
        logic prev_busy, prev_sclk;
        bit cs_bad;
        int rises_first;
        prev_busy = 1'b0;
        prev_sclk = 1'b0;
        cs_bad    = 1'b0;
        @(negedge clk);
        bus1.start     = 1'b1;
        bus1.tx_data   = 8'h5A;
        bus1.slave_sel = 2'd1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus1.busy && !prev_busy) busy_rise.push_back(t);
            if (bus1.s_clk && !prev_sclk) rise_t.push_back(t);
            if (bus1.busy && bus1.spi_cs !== 3'b010) cs_bad = 1'b1;
            if (bus1.done) begin
                done_t.push_back(t);
                $display("xfer dut1 done t=%0d rx=%02h", t, bus1.rx_data);
                if (done_t.size() == 3) bus1.start = 1'b0;
            end
            prev_busy = bus1.busy;
            prev_sclk = bus1.s_clk;
        end
        bus1.start = 1'b0;
        total_cnt++;
        if (busy_rise.size() !== 3 || done_t.size() !== 3) begin
            $display("FAIL b2b_count: got starts=%0d dones=%0d expected 3/3", busy_rise.size(), done_t.size());
        end else begin
            pass_cnt++;
            total_cnt++;
            if (done_t[0] - busy_rise[0] !== 21)
                $display("FAIL b2b_latency: got %0d expected 21", done_t[0] - busy_rise[0]);
            else pass_cnt++;
            total_cnt++;
            if (busy_rise[1] - done_t[0] !== 1)
                $display("FAIL b2b_idle_gap: got %0d expected 1", busy_rise[1] - done_t[0]);
            else pass_cnt++;
            total_cnt++;
            if (done_t[2] - done_t[1] !== 22)
                $display("FAIL b2b_period: got %0d expected 22", done_t[2] - done_t[1]);
            else pass_cnt++;
            rises_first = 0;
            foreach (rise_t[i]) if (rise_t[i] < done_t[0]) rises_first++;
            total_cnt++;
            if (rises_first !== 8) $display("FAIL b2b_rises: got %0d expected 8", rises_first); else pass_cnt++;
            total_cnt++;
            if (rise_t.size() < 8 || rise_t[1] - rise_t[0] !== 2 || rise_t[7] - rise_t[0] !== 14)
                $display("FAIL b2b_halfperiod: got spacing %0d/%0d expected 2/14",
                         rise_t[1] - rise_t[0], rise_t[7] - rise_t[0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus1.rx_data !== 8'h5A) $display("FAIL b2b_rx: got %02h expected 5a", bus1.rx_data); else pass_cnt++;
        total_cnt++;
        if (cs_bad !== 1'b0) $display("FAIL b2b_cs: got bad=%0d expected 0 (cs 010)", cs_bad); else pass_cnt++;
    endtask

    task automatic test_bad_sel();
        bit cs_seen, got_done;
        int lat;
        cs_seen  = 1'b0;
        got_done = 1'b0;
        lat      = -1;
        @(negedge clk);
        bus1.start     = 1'b1;
        bus1.tx_data   = 8'hC3;
        bus1.slave_sel = 2'd3;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int n = 0; n < 60 && !got_done; n++) begin
            if (bus1.spi_cs !== 3'b000) cs_seen = 1'b1;
            if (bus1.done) begin
                got_done = 1'b1;
                lat      = n;
            end else @(negedge clk);
        end
        $display("xfer dut1 tx=c3 sel=3 rx=%02h lat=%0d", bus1.rx_data, lat);
        total_cnt++;
        if (cs_seen !== 1'b0) $display("FAIL badsel_cs: got asserted=%0d expected 0", cs_seen); else pass_cnt++;
        total_cnt++;
        if (lat !== 21) $display("FAIL badsel_latency: got %0d expected 21", lat); else pass_cnt++;
        total_cnt++;
        if (bus1.rx_data !== 8'hC3) $display("FAIL badsel_rx: got %02h expected c3", bus1.rx_data); else pass_cnt++;
    endtask

    task automatic test_bit_order();
        int lat, rises, dones, busy_cycles;
        logic [7:0] mw;
        logic [7:0] exp_word;
        bit cs_bad, mosi_high, rx_moved;
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
        exp_word = 8'h80;
`else
        exp_word = 8'h01;
`endif
        loop0 = 1'b1;
        xfer0(8'h01, 2'd0, -1, 2, lat, rises, mw, dones, busy_cycles, cs_bad, mosi_high, rx_moved);
        total_cnt++;
        if (mw !== exp_word) $display("FAIL order_mosi: got %02h expected %02h", mw, exp_word); else pass_cnt++;
        total_cnt++;
        if (bus0.rx_data !== 8'h01) $display("FAIL order_rx: got %02h expected 01", bus0.rx_data); else pass_cnt++;
    endtask

    initial begin
        reset0         = 1'b1;
        reset1         = 1'b1;
        loop0          = 1'b1;
        miso_val0      = 1'b0;
        bus0.start     = 1'b0;
        bus0.tx_data   = 8'h00;
        bus0.slave_sel = 2'd0;
        bus1.start     = 1'b0;
        bus1.tx_data   = 8'h00;
        bus1.slave_sel = 2'd0;
        test_reset();
        test_loopback();
        test_restart_ignored();
        test_mid_reset();
        test_miso_fixed();
        test_back_to_back();
        test_bad_sel();
        test_bit_order();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
